// File: rtl/muldiv_issue_ctrl.sv
// Issue controller that freezes EX while the RV32M unit works.
// Holds operands for mult_div, pulses start, and returns result to WB.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid, ex_opcode,
//   ex_funct3, ex_funct7,
//   ex_rd                    instruction fields currently in EX
//   ex_rs1_val, ex_rs2_val   forwarded source operands
//   flush                    squash the instruction in EX
//   md_start, md_isMulDiv    start pulse to mult_div (same signal)
//   md_A, md_B               operands held for the whole operation
//   md_funct3, md_funct7     function fields held for the operation
//   md_ready, md_result      done pulse and result from mult_div
//   stall                    freeze IF/ID/EX (combinational)
//   wb_valid, wb_rd, wb_data one-cycle writeback request
//   md_err                   sticky flag, set when the unit times out
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [6:0]  ex_funct7,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic        flush,
  output logic        md_start,
  output logic        md_isMulDiv,
  output logic [31:0] md_A,
  output logic [31:0] md_B,
  output logic [2:0]  md_funct3,
  output logic [6:0]  md_funct7,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        md_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_m;

  // rd == x0 is an architectural NOP, so it is never issued.
  assign is_m = ex_valid
              && (ex_opcode == 7'b0110011)
              && (ex_funct7 == 7'b0000001)
              && (ex_rd != 5'd0)
              && !flush;

  // A new M op waiting behind a drain must stay frozen in EX.
  assign stall = ((state == S_IDLE) && is_m)
               || (state == S_ISSUE)
               || (state == S_WAIT)
               || ((state == S_DRAIN) && is_m);

  assign md_isMulDiv = md_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      md_start  <= 1'b0;
      wb_valid  <= 1'b0;
      md_err    <= 1'b0;
      md_A      <= '0;
      md_B      <= '0;
      md_funct3 <= '0;
      md_funct7 <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      md_start <= 1'b0;
      wb_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (is_m) begin
            md_A      <= ex_rs1_val;
            md_B      <= ex_rs2_val;
            md_funct3 <= ex_funct3;
            md_funct7 <= ex_funct7;
            wb_rd     <= ex_rd;
            md_start  <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (md_ready) begin
            wb_data  <= md_result;
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else if (flush) begin
            state <= S_DRAIN;
          end else if (cnt == LAST) begin
            md_err   <= 1'b1;
            wb_data  <= '0;
            wb_valid <= 1'b1;
            state    <= S_WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        S_DRAIN: begin
          // Unit cannot be aborted; discard its result.
          if (md_ready) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl with a behavioural RV32M unit model.
// Random and directed operations, flush, drain and timeout scenarios.
module tb_muldiv_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = 7'b0110011;
  logic [2:0]  ex_funct3 = '0;
  logic [6:0]  ex_funct7 = 7'b0000001;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_rs1_val = '0;
  logic [31:0] ex_rs2_val = '0;
  logic        flush = 1'b0;
  logic        md_start;
  logic        md_isMulDiv;
  logic [31:0] md_A;
  logic [31:0] md_B;
  logic [2:0]  md_funct3;
  logic [6:0]  md_funct7;
  logic        md_ready = 1'b0;
  logic [31:0] md_result = '0;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_err;

  int checks = 0;
  int errors = 0;

  int start_cnt = 0;
  int wb_cnt = 0;
  int lat_cfg = 0;
  int last_lat = 0;
  bit stub = 1'b0;

  bit          busy = 1'b0;
  int          cnt_m = 0;
  logic [31:0] cap_a, cap_b;
  logic [2:0]  cap_f3;

  muldiv_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_funct3   (ex_funct3),
    .ex_funct7   (ex_funct7),
    .ex_rd       (ex_rd),
    .ex_rs1_val  (ex_rs1_val),
    .ex_rs2_val  (ex_rs2_val),
    .flush       (flush),
    .md_start    (md_start),
    .md_isMulDiv (md_isMulDiv),
    .md_A        (md_A),
    .md_B        (md_B),
    .md_funct3   (md_funct3),
    .md_funct7   (md_funct7),
    .md_ready    (md_ready),
    .md_result   (md_result),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .md_err      (md_err)
  );

  always #5 clk = ~clk;

  // RV32M arithmetic reference.
  function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [63:0] ua64, ub64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Multi-cycle unit model: ready N cycles after the start cycle.
  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      md_ready = 1'b0;
    end else begin
      md_ready = 1'b0;
      if (busy) begin
        checks++;
        if (md_A !== cap_a || md_B !== cap_b || md_funct3 !== cap_f3) begin
          errors++;
          $display("FAIL operand_hold A=%h B=%h f3=%0d want A=%h B=%h f3=%0d",
                   md_A, md_B, md_funct3, cap_a, cap_b, cap_f3);
        end
        cnt_m--;
        if (cnt_m == 0) begin
          md_ready = 1'b1;
          md_result = ref_md(cap_f3, cap_a, cap_b);
          busy = 1'b0;
        end
      end
      if (md_start) begin
        start_cnt++;
        checks++;
        if (busy || md_isMulDiv !== 1'b1) begin
          errors++;
          $display("FAIL start_ok busy=%0d isMulDiv=%b want busy=0 isMulDiv=1",
                   busy, md_isMulDiv);
        end
        if (!stub) begin
          busy = 1'b1;
          cap_a = md_A;
          cap_b = md_B;
          cap_f3 = md_funct3;
          last_lat = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 6));
          cnt_m = last_lat;
        end
      end
      if (wb_valid) wb_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic present(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    ex_valid = 1'b1;
    ex_opcode = 7'b0110011;
    ex_funct7 = 7'b0000001;
    ex_funct3 = f3;
    ex_rd = rd;
    ex_rs1_val = a;
    ex_rs2_val = b;
  endtask

  // Hold an instruction in EX until it retires; return what WB showed.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        output int nstall, output logic wv,
                        output logic [4:0] wr, output logic [31:0] wd);
    bit done;
    nstall = 0;
    wv = 1'b0;
    wr = '0;
    wd = '0;
    done = 1'b0;
    @(negedge clk);
    present(f3, a, b, rd);
    for (int i = 0; i < 200; i++) begin
      #1;
      if (stall === 1'b1) begin
        nstall++;
      end else begin
        wv = wb_valid;
        wr = wb_rd;
        wd = wb_data;
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout stall still %b after 200 cycles", stall);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ex_valid = 1'b0;
    flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({md_start, md_isMulDiv, wb_valid, md_err, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {md_start, md_isMulDiv, wb_valid, md_err, stall});
    end
    checks++;
    if (md_A !== 0 || md_B !== 0 || md_funct3 !== 0 || md_funct7 !== 0 ||
        wb_rd !== 0 || wb_data !== 0) begin
      errors++;
      $display("FAIL reset_data A=%h B=%h f3=%h f7=%h rd=%h d=%h want all 0",
               md_A, md_B, md_funct3, md_funct7, wb_rd, wb_data);
    end
  endtask

  task automatic test_mul();
    int n, s0, w0;
    logic wv;
    logic [4:0] wr;
    logic [31:0] wd;
    lat_cfg = 3;
    s0 = start_cnt;
    w0 = wb_cnt;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, n, wv, wr, wd);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL mul_stall_len got %0d want 5", n);
    end
    checks++;
    if (wv !== 1'b1 || wr !== 5'd5 || wd !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mul_wb got v=%b rd=%0d d=%h want v=1 rd=5 d=ffffffeb",
               wv, wr, wd);
    end
    idle();
    checks++;
    if (wb_valid !== 1'b0 || wb_cnt != w0 + 1 || start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL mul_pulses got wbv=%b wb=%0d st=%0d want 0 %0d %0d",
               wb_valid, wb_cnt - w0, start_cnt - s0, 1, 1);
    end
  endtask

  task automatic test_divzero();
    int n, s0;
    logic wv;
    logic [4:0] wr;
    logic [31:0] wd;
    lat_cfg = 4;
    s0 = start_cnt;
    run_op(3'd4, 32'd100, 32'd0, 5'd3, n, wv, wr, wd);
    checks++;
    if (wv !== 1'b1 || wr !== 5'd3 || wd !== 32'hFFFF_FFFF || n != 6) begin
      errors++;
      $display("FAIL div0 got v=%b rd=%0d d=%h n=%0d want 1 3 ffffffff 6",
               wv, wr, wd, n);
    end
    idle();
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL div0_starts got %0d want 1", start_cnt - s0);
    end
    lat_cfg = 2;
    s0 = start_cnt;
    run_op(3'd7, 32'd100, 32'd0, 5'd4, n, wv, wr, wd);
    checks++;
    if (wv !== 1'b1 || wr !== 5'd4 || wd !== 32'd100 || n != 4) begin
      errors++;
      $display("FAIL remu0 got v=%b rd=%0d d=%h n=%0d want 1 4 00000064 4",
               wv, wr, wd, n);
    end
    idle();
    checks++;
    if (start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL remu0_starts got %0d want 1", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int n, s0, w0, l1;
    logic wv;
    logic [4:0] wr;
    logic [31:0] wd;
    lat_cfg = 0;
    s0 = start_cnt;
    w0 = wb_cnt;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, n, wv, wr, wd);
    l1 = last_lat;
    checks++;
    if (wv !== 1'b1 || wr !== 5'd10 || wd !== 32'hFFFF_FFFE || n != l1 + 2) begin
      errors++;
      $display("FAIL b2b_mulhu got v=%b rd=%0d d=%h n=%0d want 1 10 fffffffe %0d",
               wv, wr, wd, n, l1 + 2);
    end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, n, wv, wr, wd);
    checks++;
    if (wv !== 1'b1 || wr !== 5'd11 || wd !== 32'h8000_0000 || n != last_lat + 2) begin
      errors++;
      $display("FAIL b2b_div got v=%b rd=%0d d=%h n=%0d want 1 11 80000000 %0d",
               wv, wr, wd, n, last_lat + 2);
    end
    idle();
    checks++;
    if (wb_cnt != w0 + 2 || start_cnt != s0 + 2) begin
      errors++;
      $display("FAIL b2b_counts got wb=%0d st=%0d want 2 2",
               wb_cnt - w0, start_cnt - s0);
    end
  endtask

  task automatic test_rd0();
    int s0, w0, hi;
    s0 = start_cnt;
    w0 = wb_cnt;
    hi = 0;
    @(negedge clk);
    present(3'd0, 32'd5, 32'd6, 5'd0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (stall !== 1'b0) hi++;
      @(negedge clk);
    end
    ex_funct7 = 7'b0000000;
    ex_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall !== 1'b0) hi++;
      @(negedge clk);
    end
    ex_valid = 1'b0;
    #1;
    checks++;
    if (hi != 0 || start_cnt != s0 || wb_cnt != w0) begin
      errors++;
      $display("FAIL rd0_nop got stall_cycles=%0d st=%0d wb=%0d want 0 0 0",
               hi, start_cnt - s0, wb_cnt - w0);
    end
  endtask

  task automatic test_flush();
    int n, s0, w0;
    logic wv;
    logic [4:0] wr;
    logic [31:0] wd;
    lat_cfg = 6;
    s0 = start_cnt;
    w0 = wb_cnt;
    @(negedge clk);
    present(3'd5, 32'd1000, 32'd7, 5'd6);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_wait_stall got %b want 1", stall);
    end
    @(negedge clk);
    flush = 1'b0;
    ex_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL drain_stall got %b want 0", stall);
    end
    @(negedge clk);
    present(3'd0, 32'd6, 32'd7, 5'd7);
    #1;
    checks++;
    if (stall !== 1'b1 || start_cnt != s0 + 1) begin
      errors++;
      $display("FAIL drain_new_op got stall=%b st=%0d want 1 1",
               stall, start_cnt - s0);
    end
    run_op(3'd0, 32'd6, 32'd7, 5'd7, n, wv, wr, wd);
    checks++;
    if (wv !== 1'b1 || wr !== 5'd7 || wd !== 32'd42 || n != 10) begin
      errors++;
      $display("FAIL flush_next got v=%b rd=%0d d=%h n=%0d want 1 7 0000002a 10",
               wv, wr, wd, n);
    end
    idle();
    checks++;
    if (wb_cnt != w0 + 1 || start_cnt != s0 + 2) begin
      errors++;
      $display("FAIL flush_counts got wb=%0d st=%0d want 1 2",
               wb_cnt - w0, start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    lat_cfg = 5;
    @(negedge clk);
    present(3'd1, 32'd123, 32'd456, 5'd12);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    #1;
    checks++;
    if (stall !== 1'b0 || md_start !== 1'b0 || wb_valid !== 1'b0 || md_A !== 0) begin
      errors++;
      $display("FAIL reset_mid got stall=%b st=%b wbv=%b A=%h want 0 0 0 0",
               stall, md_start, wb_valid, md_A);
    end
  endtask

  task automatic test_random();
    int n, sel;
    logic wv;
    logic [4:0] wr, rd;
    logic [31:0] wd, a, b, exp;
    logic [2:0] f3;
    lat_cfg = 0;
    for (int k = 0; k < 24; k++) begin
      f3 = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      rd = 5'($urandom_range(1, 31));
      exp = ref_md(f3, a, b);
      run_op(f3, a, b, rd, n, wv, wr, wd);
      checks++;
      if (wv !== 1'b1 || wr !== rd || wd !== exp || n != last_lat + 2) begin
        errors++;
        $display("FAIL rand_op f3=%0d a=%h b=%h got v=%b rd=%0d d=%h n=%0d want 1 %0d %h %0d",
                 f3, a, b, wv, wr, wd, n, rd, exp, last_lat + 2);
      end
    end
    idle();
    checks++;
    if (md_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_no_err got %b want 0", md_err);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic wv;
    logic [4:0] wr;
    logic [31:0] wd;
    stub = 1'b1;
    run_op(3'd0, 32'd3, 32'd3, 5'd9, n, wv, wr, wd);
    checks++;
    if (wv !== 1'b1 || wr !== 5'd9 || wd !== 32'd0 || n != 10 || md_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout got v=%b rd=%0d d=%h n=%0d err=%b want 1 9 0 10 1",
               wv, wr, wd, n, md_err);
    end
    idle();
    checks++;
    if (md_err !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err=%b wbv=%b want 1 0", md_err, wb_valid);
    end
    do_reset();
    stub = 1'b0;
    #1;
    checks++;
    if (md_err !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL err_reset got err=%b stall=%b want 0 0", md_err, stall);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_divzero();
    test_back_to_back();
    test_rd0();
    test_flush();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
